// File: rtl/phy_free_list_pkg.sv
// Shared definitions for the physical-register free list.
//  - Widths and sizes for the rename datapath (WAY-wide dispatch/retire).
//  - fl_ptr_t: circular-list pointer with a wrap bit.
//  - fl_ptr_add: (ptr + k) mod FL_SIZE. A single conditional subtract is
//    enough because k never exceeds WAY, and WAY is smaller than FL_SIZE.
//    This stays correct when FL_SIZE is not a power of two.
//  - fl_occupancy: the free-entry count implied by the head/tail pointers.
//    It is used by the consistency assertion in the top module.
package phy_free_list_pkg;

  localparam int WAY              = 3;
  localparam int WAY_CNT_LEN      = $clog2(WAY + 1);
  localparam int N_PHY_REG        = 64;
  localparam int N_ARCH_REG       = 32;
  localparam int PHY_REG_IDX_LEN  = $clog2(N_PHY_REG);
  localparam int ARCH_REG_IDX_LEN = $clog2(N_ARCH_REG);
  localparam int FL_SIZE          = N_PHY_REG - N_ARCH_REG;
  localparam int FL_IDX_LEN       = $clog2(FL_SIZE);
  localparam int FL_CNT_LEN       = $clog2(FL_SIZE + 1);

  typedef logic [PHY_REG_IDX_LEN-1:0]  phy_reg_idx_t;
  typedef logic [ARCH_REG_IDX_LEN-1:0] arch_reg_idx_t;
  typedef logic [WAY_CNT_LEN-1:0]      way_cnt_t;
  typedef logic [FL_CNT_LEN-1:0]       fl_cnt_t;

  typedef struct packed {
    logic                  wrap;
    logic [FL_IDX_LEN-1:0] idx;
  } fl_ptr_t;

  function automatic fl_ptr_t fl_ptr_add(fl_ptr_t ptr, way_cnt_t k);
    logic [FL_IDX_LEN:0] sum;
    fl_ptr_t             res;
    sum      = {1'b0, ptr.idx} + {{(FL_IDX_LEN + 1 - WAY_CNT_LEN){1'b0}}, k};
    res.wrap = ptr.wrap;
    if (sum >= (FL_IDX_LEN + 1)'(FL_SIZE)) begin
      sum      = sum - (FL_IDX_LEN + 1)'(FL_SIZE);
      res.wrap = ~ptr.wrap;
    end
    res.idx = sum[FL_IDX_LEN-1:0];
    return res;
  endfunction

  // Free entries live in [head, tail). When the indices are equal, the wrap
  // bits decide between the two extremes. Equal wrap bits mean full, which is
  // the state after reset and after a squash. Differing wrap bits mean empty.
  function automatic fl_cnt_t fl_occupancy(fl_ptr_t head, fl_ptr_t tail);
    logic [FL_IDX_LEN:0] diff;
    if (head.idx == tail.idx) begin
      diff = (head.wrap == tail.wrap) ? (FL_IDX_LEN + 1)'(FL_SIZE) : '0;
    end else if (tail.idx > head.idx) begin
      diff = {1'b0, tail.idx} - {1'b0, head.idx};
    end else begin
      diff = {1'b0, tail.idx} + (FL_IDX_LEN + 1)'(FL_SIZE) - {1'b0, head.idx};
    end
    return fl_cnt_t'(diff);
  endfunction

endpackage

// File: rtl/phy_free_list_alloc_compact.sv
// Allocation compaction for the free list (combinational).
//  - A way allocates when it is inside the dispatch group (i < num_to_dispatch)
//    and its destination is not x0.
//  - Each allocating way takes the k-th free entry after head. Here k counts
//    the allocating ways below it, so x0 ways leave no holes.
// Ports:
//  num_to_dispatch  in   ways 0..n-1 are dispatching
//  arch_dest_reg    in   destination arch reg per way
//  alloc_valid      out  per-way "consumes a free register"
//  alloc_offset     out  per-way offset k_i from head
//  alloc_cnt        out  total allocating ways
module fl_alloc_compact
  import phy_free_list_pkg::*;
(
  input  logic [WAY_CNT_LEN-1:0]                num_to_dispatch,
  input  logic [WAY-1:0][ARCH_REG_IDX_LEN-1:0] arch_dest_reg,
  output logic [WAY-1:0]                        alloc_valid,
  output logic [WAY-1:0][WAY_CNT_LEN-1:0]       alloc_offset,
  output logic [WAY_CNT_LEN-1:0]                alloc_cnt
);

  genvar gi;
  generate
    for (gi = 0; gi < WAY; gi++) begin : g_valid
      assign alloc_valid[gi] = (way_cnt_t'(gi) < num_to_dispatch) &&
                               (arch_dest_reg[gi] != '0);
    end
  endgenerate

  // Exclusive prefix sum of alloc_valid.
  always_comb begin
    way_cnt_t run;
    run          = '0;
    alloc_offset = '0;
    for (int i = 0; i < WAY; i++) begin
      alloc_offset[i] = run;
      run             = run + way_cnt_t'(alloc_valid[i]);
    end
    alloc_cnt = run;
  end

endmodule

// File: rtl/phy_free_list.sv
// Physical-register free list for rename.
//  - Offers up to WAY free physical registers each cycle. The offer is
//    combinational from registered state plus the current dispatch inputs.
//  - Commit returns stale physical registers at the tail.
//  - Squash restores every in-flight allocation in a single cycle.
// Ports:
//  clock, reset       rising-edge clock, synchronous active-high reset
//  num_to_dispatch    instrs dispatched this cycle (ways 0..n-1)
//  arch_dest_reg      destination arch reg per way
//  dispatch_free_reg  physical reg granted per way (0 for non-allocating ways)
//  free_reg_valid     min(count, WAY)
//  retire_num         number of stale pregs returned this cycle
//  retire_free_reg    stale pregs (ways 0..retire_num-1)
//  squash             branch mispredict recovery
module phy_free_list
  import phy_free_list_pkg::*;
(
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [WAY_CNT_LEN-1:0]                num_to_dispatch,
  input  logic [WAY-1:0][ARCH_REG_IDX_LEN-1:0] arch_dest_reg,
  output logic [WAY-1:0][PHY_REG_IDX_LEN-1:0]  dispatch_free_reg,
  output logic [WAY_CNT_LEN-1:0]                free_reg_valid,
  input  logic [WAY_CNT_LEN-1:0]                retire_num,
  input  logic [WAY-1:0][PHY_REG_IDX_LEN-1:0]  retire_free_reg,
  input  logic                                  squash
);

  phy_reg_idx_t list_reg [FL_SIZE];
  fl_ptr_t      head_reg, head_next;
  fl_ptr_t      tail_reg, tail_next;
  fl_cnt_t      count_reg, count_next;

  logic [WAY-1:0]                  alloc_valid;
  logic [WAY-1:0][WAY_CNT_LEN-1:0] alloc_offset;
  way_cnt_t                        alloc_cnt;
  way_cnt_t                        alloc_eff;
  fl_ptr_t                         wr_ptr [WAY];

  fl_alloc_compact u_alloc_compact (
    .num_to_dispatch (num_to_dispatch),
    .arch_dest_reg   (arch_dest_reg),
    .alloc_valid     (alloc_valid),
    .alloc_offset    (alloc_offset),
    .alloc_cnt       (alloc_cnt)
  );

  assign free_reg_valid = (count_reg >= fl_cnt_t'(WAY)) ? way_cnt_t'(WAY)
                                                        : count_reg[WAY_CNT_LEN-1:0];

  // Read ports: one per way, at head + k_i. Write ports: one per way, at
  // tail + j.
  genvar gi;
  generate
    for (gi = 0; gi < WAY; gi++) begin : g_port
      fl_ptr_t rd_ptr;
      assign rd_ptr                = fl_ptr_add(head_reg, alloc_offset[gi]);
      assign dispatch_free_reg[gi] = alloc_valid[gi] ? list_reg[rd_ptr.idx] : '0;
      assign wr_ptr[gi]            = fl_ptr_add(tail_reg, way_cnt_t'(gi));
    end
  endgenerate

  // On a squash, the slots [tail, head) hold exactly the in-flight allocations
  // in age order. Pulling head back to the (post-retire) tail therefore makes
  // the whole list free again.
  always_comb begin
    alloc_eff = squash ? '0 : alloc_cnt;
    tail_next = fl_ptr_add(tail_reg, retire_num);
    if (squash) begin
      head_next  = tail_next;
      count_next = fl_cnt_t'(FL_SIZE);
    end else begin
      head_next  = fl_ptr_add(head_reg, alloc_eff);
      count_next = count_reg - fl_cnt_t'(alloc_eff) + fl_cnt_t'(retire_num);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        list_reg[i] <= phy_reg_idx_t'(N_ARCH_REG + i);
      end
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= fl_cnt_t'(FL_SIZE);
    end else begin
      for (int j = 0; j < WAY; j++) begin
        if (way_cnt_t'(j) < retire_num) begin
          list_reg[wr_ptr[j].idx] <= retire_free_reg[j];
        end
      end
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Protocol and consistency checks.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (!squash) begin
        assert (alloc_cnt <= free_reg_valid);
      end
      assert (int'(count_reg) - int'(alloc_eff) + int'(retire_num) <= FL_SIZE);
      assert (count_reg == fl_occupancy(head_reg, tail_reg));
    end
  end

endmodule
